// File: rtl/locker_pkg.sv
// Shared definitions for the locker code writer.
//   KEY_W, DIGITS, CODE_W : code geometry (digit 0 lives in the MSB slot)
//   IDX_W                 : width of the digit index exposed on digit_idx
//   DEFAULT_CODE          : code loaded at reset
//   state_t               : writer FSM encoding, 4 bits wide like the checker
package locker_pkg;

   localparam int KEY_W  = 2;
   localparam int DIGITS = 4;
   localparam int CODE_W = DIGITS * KEY_W;
   localparam int IDX_W  = 2;

   localparam logic [CODE_W-1:0] DEFAULT_CODE = 8'b00_00_00_00;

   typedef enum logic [3:0] {
      ST_IDLE    = 4'd0,
      ST_ENTER   = 4'd1,
      ST_CONFIRM = 4'd2
   } state_t;

endpackage

// File: rtl/locker_timeout_counter.sv
// Idle-cycle counter for the code writer.
//   clock, clear_n : system clock, synchronous active-low reset
//   enable         : count one per cycle while high
//   clear          : force the count back to zero (wins over enable)
//   expire         : high while enabled and the count sits at LIMIT-1
module locker_timeout_counter #(
   parameter int unsigned LIMIT = 16
) (
   input  logic clock,
   input  logic clear_n,
   input  logic enable,
   input  logic clear,
   output logic expire
);

   localparam int CW = (LIMIT > 2) ? $clog2(LIMIT) : 1;

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable) begin
         count_d = count_q + CW'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (!clear_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expire = enable && (count_q == CW'(LIMIT - 1));

endmodule

// File: rtl/locker_code_writer.sv
// Programs a new door code: digits are entered once, then confirmed; the
// code register is updated only if both entries agree.
//   clock, clear_n       : system clock, synchronous active-low reset
//   unlocked             : programming permitted (sampled on prog_req only)
//   prog_req             : one-cycle request to start programming
//   key_valid, key       : one-cycle digit strobe and digit value
//   code                 : committed code, digit 0 in the MSBs
//   prog_busy, phase     : busy in ENTER/CONFIRM; phase 1 = CONFIRM
//   digit_idx            : index of the next expected digit
//   prog_done, prog_err  : one-cycle result pulses
//
// Handshake: key_valid is a single-cycle strobe with no back-pressure; a
// strobe is consumed only while busy and is dropped silently in IDLE.
module locker_code_writer
   import locker_pkg::*;
#(
   parameter int unsigned              DIGITS         = locker_pkg::DIGITS,
   parameter int unsigned              KEY_W          = locker_pkg::KEY_W,
   parameter int unsigned              TIMEOUT_CYCLES = 100_000_000,
   parameter logic [DIGITS*KEY_W-1:0]  DEFAULT_CODE   = locker_pkg::DEFAULT_CODE
) (
   input  logic                      clock,
   input  logic                      clear_n,
   input  logic                      unlocked,
   input  logic                      prog_req,
   input  logic                      key_valid,
   input  logic [KEY_W-1:0]          key,
   output logic [DIGITS*KEY_W-1:0]   code,
   output logic                      prog_busy,
   output logic                      phase,
   output logic [IDX_W-1:0]          digit_idx,
   output logic                      prog_done,
   output logic                      prog_err
);

   localparam int CODE_BITS = DIGITS * KEY_W;

   state_t                 state_q, state_d;
   logic [CODE_BITS-1:0]   shadow_q, shadow_d;
   logic [CODE_BITS-1:0]   code_q, code_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic                   mismatch_q, mismatch_d;
   logic                   done_q, done_d;
   logic                   err_q, err_d;

   logic                   timer_clear;
   logic                   timer_expire;
   logic                   last_digit;
   logic                   mismatch_now;
   logic [KEY_W-1:0]       shadow_slot;

   locker_timeout_counter #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_timeout (
      .clock   (clock),
      .clear_n (clear_n),
      .enable  (state_q != ST_IDLE),
      .clear   (timer_clear),
      .expire  (timer_expire)
   );

   assign last_digit = (idx_q == IDX_W'(DIGITS - 1));

   // Digit held in the shadow slot addressed by the current index.
   always_comb begin
      shadow_slot = '0;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (idx_q == IDX_W'(i)) begin
            shadow_slot = shadow_q[CODE_BITS-1-KEY_W*i -: KEY_W];
         end
      end
   end

   // Sticky mismatch including the compare happening this cycle.
   assign mismatch_now = mismatch_q | (key != shadow_slot);

   always_comb begin
      state_d     = state_q;
      shadow_d    = shadow_q;
      code_d      = code_q;
      idx_d       = idx_q;
      mismatch_d  = mismatch_q;
      done_d      = 1'b0;
      err_d       = 1'b0;
      timer_clear = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // Hold the timer at zero so a new entry starts from a full window.
            timer_clear = 1'b1;
            if (prog_req) begin
               if (unlocked) begin
                  state_d  = ST_ENTER;
                  idx_d    = '0;
                  shadow_d = '0;
               end else begin
                  err_d = 1'b1;
               end
            end
         end

         ST_ENTER: begin
            if (key_valid) begin
               timer_clear = 1'b1;
               for (int i = 0; i < int'(DIGITS); i++) begin
                  if (idx_q == IDX_W'(i)) begin
                     shadow_d[CODE_BITS-1-KEY_W*i -: KEY_W] = key;
                  end
               end
               if (last_digit) begin
                  state_d    = ST_CONFIRM;
                  idx_d      = '0;
                  mismatch_d = 1'b0;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end else if (timer_expire) begin
               state_d = ST_IDLE;
               idx_d   = '0;
               err_d   = 1'b1;
            end
         end

         ST_CONFIRM: begin
            if (key_valid) begin
               timer_clear = 1'b1;
               mismatch_d  = mismatch_now;
               if (last_digit) begin
                  state_d = ST_IDLE;
                  idx_d   = '0;
                  if (mismatch_now) begin
                     err_d = 1'b1;
                  end else begin
                     code_d = shadow_q;
                     done_d = 1'b1;
                  end
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end else if (timer_expire) begin
               state_d = ST_IDLE;
               idx_d   = '0;
               err_d   = 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
            idx_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!clear_n) begin
         state_q    <= ST_IDLE;
         shadow_q   <= '0;
         code_q     <= DEFAULT_CODE;
         idx_q      <= '0;
         mismatch_q <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         shadow_q   <= shadow_d;
         code_q     <= code_d;
         idx_q      <= idx_d;
         mismatch_q <= mismatch_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign code      = code_q;
   assign prog_busy = (state_q != ST_IDLE);
   assign phase     = (state_q == ST_CONFIRM);
   assign digit_idx = idx_q;
   assign prog_done = done_q;
   assign prog_err  = err_q;

endmodule

// File: tb/tb_locker_code_writer.sv
module tb_locker_code_writer;

   localparam int          TO       = 16;
   localparam logic [7:0]  DEF_CODE = 8'h00;

   // ---------------- clock / reset ----------------
   logic       clock = 1'b0;
   logic       clear_n = 1'b0;
   logic       unlocked = 1'b0;
   logic       prog_req = 1'b0;
   logic       key_valid = 1'b0;
   logic [1:0] key = 2'd0;
   logic [7:0] code;
   logic       prog_busy;
   logic       phase;
   logic [1:0] digit_idx;
   logic       prog_done;
   logic       prog_err;

   always #5 clock = ~clock;

   locker_code_writer #(
      .DIGITS         (4),
      .KEY_W          (2),
      .TIMEOUT_CYCLES (TO),
      .DEFAULT_CODE   (DEF_CODE)
   ) dut (
      .clock     (clock),
      .clear_n   (clear_n),
      .unlocked  (unlocked),
      .prog_req  (prog_req),
      .key_valid (key_valid),
      .key       (key),
      .code      (code),
      .prog_busy (prog_busy),
      .phase     (phase),
      .digit_idx (digit_idx),
      .prog_done (prog_done),
      .prog_err  (prog_err)
   );

   // ---------------- scoreboard ----------------
   int         n_checks = 0;
   int         n_errors = 0;
   logic [7:0] model_code;
   logic [7:0] exp_q[$];
   int         done_cnt = 0;
   int         err_cnt = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Pulse tally, sampled just after each active edge.
   always @(posedge clock) begin
      #2;
      if (clear_n) begin
         done_cnt = done_cnt + int'(prog_done);
         err_cnt  = err_cnt + int'(prog_err);
         if (prog_done || prog_err) check("done_err_exclusive", {prog_done, prog_err} == 2'b11, 0);
      end
   end

   // ---------------- driver tasks ----------------
   // Called at a negedge; drives inputs for one posedge and returns at the next negedge.
   task automatic step(input logic pr, input logic kv, input logic [1:0] k);
      prog_req  = pr;
      key_valid = kv;
      key       = k;
      @(negedge clock);
      prog_req  = 1'b0;
      key_valid = 1'b0;
      key       = 2'($urandom_range(0, 3));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'd0);
   endtask

   task automatic press(input logic [1:0] k, input int gap);
      idle(gap);
      step(1'b0, 1'b1, k);
   endtask

   function automatic logic [1:0] digit_of(input logic [7:0] c, input int i);
      return 2'((c >> (6 - 2 * i)) & 8'h3);
   endfunction

   // One full programming attempt judged by the model: commit only if entries agree.
   task automatic run_prog(input logic [7:0] a, input logic [7:0] b, input bit unl);
      int d0, e0;
      logic [7:0] expect_code;
      d0 = done_cnt;
      e0 = err_cnt;
      unlocked = unl;
      step(1'b1, 1'b0, 2'd0);
      if (!unl) begin
         check("refused_err", prog_err, 1);
         check("refused_busy", prog_busy, 0);
         check("refused_code", code, model_code);
         idle(1);
         check("refused_err_pulse", err_cnt - e0, 1);
         return;
      end
      check("start_busy", prog_busy, 1);
      check("start_phase", phase, 0);
      for (int i = 0; i < 4; i++) begin
         press(digit_of(a, i), $urandom_range(0, 3));
         if ($urandom_range(0, 1) == 1) unlocked = 1'b0;
         if (i < 3) check("enter_idx", digit_idx, i + 1);
      end
      check("confirm_phase", phase, 1);
      check("confirm_idx", digit_idx, 0);
      for (int i = 0; i < 4; i++) begin
         press(digit_of(b, i), $urandom_range(0, 3));
         if (i < 3) check("confirm_step_idx", digit_idx, i + 1);
      end
      if (a == b) model_code = a;
      exp_q.push_back(model_code);
      expect_code = exp_q.pop_front();
      check("final_code", code, expect_code);
      check("final_done", prog_done, (a == b) ? 1 : 0);
      check("final_err", prog_err, (a != b) ? 1 : 0);
      check("final_busy", prog_busy, 0);
      idle(1);
      check("done_pulse_count", done_cnt - d0, (a == b) ? 1 : 0);
      check("err_pulse_count", err_cnt - e0, (a != b) ? 1 : 0);
      check("pulse_low_after", {prog_done, prog_err}, 0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      model_code = DEF_CODE;
      @(negedge clock);
      idle(2);
      clear_n = 1'b1;
      check("reset_code", code, DEF_CODE);
      check("reset_busy", prog_busy, 0);
      check("reset_pulses", {prog_done, prog_err, phase}, 0);
      check("reset_idx", digit_idx, 0);

      // Keys while idle must be ignored.
      press(2'd3, 0);
      check("idle_key_ignored", {prog_busy, digit_idx}, 0);

      run_prog(8'h00, 8'h00, 1'b0);
      run_prog(8'b10_01_11_00, 8'b10_01_11_00, 1'b1);
      run_prog(8'b10_01_11_00, 8'b10_01_11_01, 1'b1);

      // Timeout: two keys then a silent window of TO cycles.
      begin
         int e0;
         unlocked = 1'b1;
         step(1'b1, 1'b0, 2'd0);
         press(2'd1, 0);
         press(2'd2, 1);
         e0 = err_cnt;
         idle(TO - 1);
         check("timeout_not_yet", prog_busy, 1);
         idle(1);
         check("timeout_busy", prog_busy, 0);
         check("timeout_err", prog_err, 1);
         check("timeout_code", code, model_code);
         idle(1);
         check("timeout_err_count", err_cnt - e0, 1);
      end

      // A key in the expiring cycle is accepted.
      begin
         int e0;
         e0 = err_cnt;
         step(1'b1, 1'b0, 2'd0);
         press(2'd1, 0);
         idle(TO - 1);
         press(2'd3, 0);
         check("late_key_busy", prog_busy, 1);
         check("late_key_idx", digit_idx, 2);
         check("late_key_no_err", err_cnt - e0, 0);
         // prog_req while busy is ignored.
         step(1'b1, 1'b0, 2'd0);
         check("req_busy_idx", digit_idx, 2);
         check("req_busy_phase", phase, 0);
         press(2'd0, 0);
         press(2'd2, 0);
         check("late_enter_phase", phase, 1);
         press(2'd1, 0);
         press(2'd3, 0);
         check("mid_confirm_idx", digit_idx, 2);
         // Reset mid-confirm.
         clear_n = 1'b0;
         idle(1);
         clear_n = 1'b1;
         model_code = DEF_CODE;
         check("midreset_code", code, DEF_CODE);
         check("midreset_state", {prog_busy, phase, digit_idx}, 0);
         check("midreset_pulses", {prog_done, prog_err}, 0);
         idle(1);
         check("midreset_quiet", {prog_done, prog_err, prog_busy}, 0);
      end

      // Randomised attempts against the model.
      for (int t = 0; t < 20; t++) begin
         logic [7:0] a, b;
         int kind;
         a = 8'($urandom_range(0, 255));
         kind = $urandom_range(0, 5);
         if (kind <= 2) b = a;
         else if (kind == 3) b = a ^ (8'h1 << $urandom_range(0, 7));
         else b = 8'($urandom_range(0, 255));
         run_prog(a, b, (kind == 5) ? 1'b0 : 1'b1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
